pc_unit_v2: RTL and testbench
=============================

// Module: pc_unit_v2
// PURPOSE
//   Parametrised fetch-stage program counter for the MIPS150 pipeline.
//   Selects next PC from PC+4 / branch / JR / JAL / exception vector, drives the
//   synchronous IMEM address (PC_IMEM) combinationally and registers PC_IF.
//   Adds boot sequencing, configurable post-flush bubble count, exception
//   redirect, target alignment and a redirect epoch tag for downstream squash.
// PARAMETERS
//   PC_W          32            PC width in bits (>= 8)
//   RESET_VECTOR  32'h0000_0000 first fetch address after reset
//   EXC_VECTOR    32'h0000_0180 target loaded on exc
//   FLUSH_CYCLES  3             bubble cycles after a redirect (1..15)
//   EPOCH_W       2             width of redirect epoch counter (1..8)
// PORTS
//   CLK        in   1      clock, all state on rising edge
//   RST        in   1      asynchronous reset, active-high
//   EN         in   1      1 = advance PC; 0 = stall (hold) in RUN
//   PC_Sel     in   2      00 PC_4, 01 PC_Branch, 10 JR, 11 PC_JAL
//   PC_4       in   PC_W   sequential next PC
//   PC_Branch  in   PC_W   branch target
//   JR         in   PC_W   register jump target
//   PC_JAL     in   PC_W   J/JAL target
//   flush      in   1      redirect pulse: take PC_Sel target, start bubbles
//   exc        in   1      exception pulse: redirect to EXC_VECTOR
//   PC_IMEM    out  PC_W   combinational next-PC to IMEM address port
//   PC_IF      out  PC_W   registered PC of instruction now in IF
//   pc_valid   out  1      PC_IF holds a real (non-bubble) fetch
//   flushing   out  1      1 while in FLUSH state
//   misalign   out  1      registered: last loaded target had [1:0]!=0
//   epoch      out  EPOCH_W increments on every accepted flush/exc, wraps
// BEHAVIOUR
//   Reset (async, RST=1): state=BOOT, PC_IF=RESET_VECTOR, pc_valid=0,
//     flushing=0, misalign=0, epoch=0, bubble count=0; PC_IMEM=RESET_VECTOR.
//   States: BOOT, RUN, FLUSH. sel_tgt = mux(PC_Sel); tgt[1:0] forced to 2'b00.
//   Next-PC priority (evaluated each cycle, PC_IMEM = next PC):
//     1 exc  -> EXC_VECTOR, ignores EN, -> FLUSH, epoch+1
//     2 flush-> sel_tgt, ignores EN, -> FLUSH, epoch+1
//     3 BOOT -> RESET_VECTOR, -> RUN (one cycle after RST release)
//     4 FLUSH-> hold PC_IF; count down; at count==1 -> RUN
//     5 RUN & EN -> sel_tgt; RUN & ~EN -> hold PC_IF
//   Redirect loads PC_IF on the same edge; count <= FLUSH_CYCLES; pc_valid=0
//     throughout FLUSH, returns to 1 on first RUN cycle PC_IF updates.
//   pc_valid: 0 in BOOT/FLUSH; 1 after any RUN load; unchanged on RUN stall.
//   flush/exc arriving during FLUSH: reload target, restart count, epoch+1.
//   flush and exc same cycle: exc wins, epoch increments once.
//   flush/exc during BOOT: honoured (priority above BOOT).
//   epoch wraps 2^EPOCH_W-1 -> 0; PC arithmetic is external, no carry checks.
//   misalign set on any load whose raw target[1:0]!=0, cleared on next clean
//     load; held on stall/hold cycles.
//   RST mid-FLUSH: immediate return to reset values, pending bubbles dropped.
//   No latches: every comb output fully assigned (default = hold PC_IF).
// STRUCTURE
//   Package pc_pkg: PC_Sel encodings (PCSEL_PC4/BR/JR/JAL), state enum
//     (ST_BOOT/ST_RUN/ST_FLUSH), default vector constants.
//   Sub-module pc_bubble_ctr: loadable down-counter (width clog2(FLUSH_CYCLES+1)),
//     load/dec inputs, done output; top holds FSM, next-PC mux, PC/epoch regs.
// TESTING
//   RST 1->0, EN=1, PC_Sel=00, PC_4=PC_IF+4 -> PC_IF 0x0,0x4,0x8; pc_valid 0,1,1.
//   RUN, PC_Sel=01, PC_Branch=0x40, flush=1 one cycle -> PC_IF=0x40 next edge,
//     flushing=1 and pc_valid=0 for 3 cycles, epoch 0->1, then 0x44.
//   flush and exc same cycle with PC_JAL=0x100 -> PC_IF=0x180, epoch+1 only once.
//   second flush at bubble 2 (JR=0x200) -> PC_IF=0x200, 3 fresh bubbles, epoch+1.
//   EN=0 for 4 cycles in RUN -> PC_IF, pc_valid, PC_IMEM==PC_IF all stable.
//   JR=0x203 flush -> PC_IF=0x200, misalign=1; RST asserted mid-FLUSH ->
//     PC_IF=RESET_VECTOR, flushing=0, epoch=0 without waiting for CLK edge.

Source files
------------

// File: rtl/pc_pkg.sv
// Shared encodings and default vectors for the fetch-stage program counter.
package pc_pkg;

  typedef enum logic [1:0] {
    PCSEL_PC4 = 2'b00,
    PCSEL_BR  = 2'b01,
    PCSEL_JR  = 2'b10,
    PCSEL_JAL = 2'b11
  } pc_sel_e;

  typedef enum logic [1:0] {
    ST_BOOT,
    ST_RUN,
    ST_FLUSH
  } state_e;

  localparam logic [31:0] DEF_RESET_VECTOR = 32'h0000_0000;
  localparam logic [31:0] DEF_EXC_VECTOR   = 32'h0000_0180;

endpackage

// File: rtl/pc_unit_v2_if.sv
// Fetch-stage PC bus: pipeline-side controls/targets in, IMEM/IF-side PC state out.
interface pc_unit_v2_if #(
  parameter int PC_W    = 32,
  parameter int EPOCH_W = 2
);
  logic              EN;
  logic [1:0]        PC_Sel;
  logic [PC_W-1:0]   PC_4;
  logic [PC_W-1:0]   PC_Branch;
  logic [PC_W-1:0]   JR;
  logic [PC_W-1:0]   PC_JAL;
  logic              flush;
  logic              exc;
  logic [PC_W-1:0]   PC_IMEM;
  logic [PC_W-1:0]   PC_IF;
  logic              pc_valid;
  logic              flushing;
  logic              misalign;
  logic [EPOCH_W-1:0] epoch;

  modport master (
    output EN, PC_Sel, PC_4, PC_Branch, JR, PC_JAL, flush, exc,
    input  PC_IMEM, PC_IF, pc_valid, flushing, misalign, epoch
  );

  modport slave (
    input  EN, PC_Sel, PC_4, PC_Branch, JR, PC_JAL, flush, exc,
    output PC_IMEM, PC_IF, pc_valid, flushing, misalign, epoch
  );
endinterface

// File: rtl/pc_bubble_ctr.sv
// Loadable down-counter timing the post-redirect bubble window.
module pc_bubble_ctr #(
  parameter int CW       = 2,
  parameter int LOAD_VAL = 3
) (
  input  logic CLK,
  input  logic RST,
  input  logic load,
  input  logic dec,
  output logic done
);
  logic [CW-1:0] count_q;

  always_ff @(posedge CLK or posedge RST) begin
    if (RST)
      count_q <= '0;
    else if (load)
      count_q <= CW'(LOAD_VAL);
    else if (dec && count_q != '0)
      count_q <= count_q - CW'(1);
  end

  assign done = (count_q == CW'(1));
endmodule

// File: rtl/pc_unit_v2.sv
// MIPS150 fetch-stage PC: next-PC select with boot, flush/exception redirect,
// bubble window, alignment forcing and a redirect epoch tag.
module pc_unit_v2
  import pc_pkg::*;
#(
  parameter int              PC_W         = 32,
  parameter logic [PC_W-1:0] RESET_VECTOR = PC_W'(DEF_RESET_VECTOR),
  parameter logic [PC_W-1:0] EXC_VECTOR   = PC_W'(DEF_EXC_VECTOR),
  parameter int              FLUSH_CYCLES = 3,
  parameter int              EPOCH_W      = 2
) (
  input logic          CLK,
  input logic          RST,
  pc_unit_v2_if.slave  bus
);
  localparam int CNT_W = $clog2(FLUSH_CYCLES + 1);

  state_e             state_q, state_d;
  logic [PC_W-1:0]    pc_q, next_pc, raw_tgt, sel_tgt;
  logic               valid_q, valid_d, mis_q, mis_d;
  logic [EPOCH_W-1:0] epoch_q;
  logic               epoch_inc, cnt_load, cnt_dec, cnt_done;

  always_comb begin
    raw_tgt = bus.PC_4;
    case (bus.PC_Sel)
      PCSEL_BR:  raw_tgt = bus.PC_Branch;
      PCSEL_JR:  raw_tgt = bus.JR;
      PCSEL_JAL: raw_tgt = bus.PC_JAL;
      default:   raw_tgt = bus.PC_4;
    endcase
  end

  assign sel_tgt = {raw_tgt[PC_W-1:2], 2'b00};

  // Redirects sit above the state-driven choices, so they win even in BOOT/FLUSH.
  always_comb begin
    next_pc   = pc_q;
    state_d   = state_q;
    valid_d   = valid_q;
    mis_d     = mis_q;
    epoch_inc = 1'b0;
    cnt_load  = 1'b0;
    cnt_dec   = 1'b0;
    if (bus.exc) begin
      next_pc   = EXC_VECTOR;
      state_d   = ST_FLUSH;
      valid_d   = 1'b0;
      mis_d     = |EXC_VECTOR[1:0];
      epoch_inc = 1'b1;
      cnt_load  = 1'b1;
    end else if (bus.flush) begin
      next_pc   = sel_tgt;
      state_d   = ST_FLUSH;
      valid_d   = 1'b0;
      mis_d     = |raw_tgt[1:0];
      epoch_inc = 1'b1;
      cnt_load  = 1'b1;
    end else begin
      case (state_q)
        ST_BOOT: begin
          next_pc = RESET_VECTOR;
          state_d = ST_RUN;
          valid_d = 1'b0;
          mis_d   = |RESET_VECTOR[1:0];
        end
        ST_FLUSH: begin
          cnt_dec = 1'b1;
          valid_d = 1'b0;
          if (cnt_done) state_d = ST_RUN;
        end
        default: begin
          if (bus.EN) begin
            next_pc = sel_tgt;
            valid_d = 1'b1;
            mis_d   = |raw_tgt[1:0];
          end
        end
      endcase
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q <= ST_BOOT;
      pc_q    <= RESET_VECTOR;
      valid_q <= 1'b0;
      mis_q   <= 1'b0;
      epoch_q <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= next_pc;
      valid_q <= valid_d;
      mis_q   <= mis_d;
      if (epoch_inc) epoch_q <= epoch_q + EPOCH_W'(1);
    end
  end

  pc_bubble_ctr #(
    .CW       (CNT_W),
    .LOAD_VAL (FLUSH_CYCLES)
  ) u_bubble (
    .CLK  (CLK),
    .RST  (RST),
    .load (cnt_load),
    .dec  (cnt_dec),
    .done (cnt_done)
  );

  assign bus.PC_IMEM  = next_pc;
  assign bus.PC_IF    = pc_q;
  assign bus.pc_valid = valid_q;
  assign bus.flushing = (state_q == ST_FLUSH);
  assign bus.misalign = mis_q;
  assign bus.epoch    = epoch_q;
endmodule

// File: tb/tb_pc_unit_v2.sv
// Scoreboarded bench for pc_unit_v2: a cycle-level reference model queues the
// expected outputs, a negedge monitor compares them against the DUT.
module tb_pc_unit_v2;
  localparam logic [31:0] RV = 32'h0000_0000;
  localparam logic [31:0] EV = 32'h0000_0180;
  localparam int          FC = 3;
  localparam int          EW = 2;

  logic CLK = 1'b0;
  logic RST = 1'b1;
  always #5 CLK = ~CLK;

  pc_unit_v2_if #(.PC_W(32), .EPOCH_W(EW)) bus ();

  pc_unit_v2 #(
    .PC_W         (32),
    .RESET_VECTOR (RV),
    .EXC_VECTOR   (EV),
    .FLUSH_CYCLES (FC),
    .EPOCH_W      (EW)
  ) dut (
    .CLK (CLK),
    .RST (RST),
    .bus (bus)
  );

  typedef struct {
    logic [31:0] pc;
    bit          valid;
    bit          mis;
    int          epoch;
    bit          boot;
    int          bub;
  } model_t;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] imem;
    bit          valid;
    bit          flushing;
    bit          mis;
    logic [1:0]  epoch;
  } exp_t;

  exp_t   sb[$];
  model_t m;
  int     total = 0;
  int     bad   = 0;
  bit     running   = 1'b0;
  bit     stim_done = 1'b0;

  function automatic model_t reset_state();
    model_t r;
    r.pc = RV; r.valid = 1'b0; r.mis = 1'b0; r.epoch = 0; r.boot = 1'b1; r.bub = 0;
    return r;
  endfunction

  // What the fetch stage should hold after one clock edge with these inputs.
  function automatic model_t advance(model_t s, bit en, bit fl, bit ex, logic [31:0] raw);
    model_t n = s;
    if (ex) begin
      n.pc = EV; n.bub = FC; n.valid = 1'b0; n.mis = (EV % 4) != 0;
      n.epoch = (s.epoch + 1) % (1 << EW); n.boot = 1'b0;
    end else if (fl) begin
      n.pc = raw & ~32'd3; n.bub = FC; n.valid = 1'b0; n.mis = (raw % 4) != 0;
      n.epoch = (s.epoch + 1) % (1 << EW); n.boot = 1'b0;
    end else if (s.boot) begin
      n.pc = RV; n.boot = 1'b0; n.valid = 1'b0; n.mis = (RV % 4) != 0;
    end else if (s.bub > 0) begin
      n.bub = s.bub - 1;
    end else if (en) begin
      n.pc = raw & ~32'd3; n.valid = 1'b1; n.mis = (raw % 4) != 0;
    end
    return n;
  endfunction

  task automatic push_exp(model_t s, logic [31:0] imem);
    exp_t e;
    e.pc = s.pc; e.imem = imem; e.valid = s.valid;
    e.flushing = (s.bub > 0); e.mis = s.mis; e.epoch = 2'(s.epoch);
    sb.push_back(e);
    running = 1'b1;
  endtask

  // Called at posedge+1: drive one cycle of inputs, queue expectations, step the model.
  task automatic drive(bit en, logic [1:0] sel, logic [31:0] br, logic [31:0] jr,
                       logic [31:0] jal, bit fl, bit ex);
    logic [31:0] raw;
    model_t nx;
    case (sel)
      2'b00:   raw = m.pc + 32'd4;
      2'b01:   raw = br;
      2'b10:   raw = jr;
      default: raw = jal;
    endcase
    bus.EN = en; bus.PC_Sel = sel; bus.PC_4 = m.pc + 32'd4;
    bus.PC_Branch = br; bus.JR = jr; bus.PC_JAL = jal;
    bus.flush = fl; bus.exc = ex;
    nx = advance(m, en, fl, ex, raw);
    push_exp(m, nx.pc);
    @(posedge CLK);
    #1;
    m = nx;
  endtask

  // Reset raised mid-cycle: the monitor sees the result before any clock edge.
  task automatic do_rst();
    RST = 1'b1;
    bus.EN = 1'b0; bus.PC_Sel = 2'b00; bus.flush = 1'b0; bus.exc = 1'b0;
    m = reset_state();
    push_exp(m, RV);
    @(posedge CLK);
    #1;
    RST = 1'b0;
  endtask

  task automatic chk(string name, logic [31:0] act, logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %h want %h (t=%0t)", name, act, req, $time);
    end
  endtask

  exp_t e;
  initial begin
    forever begin
      @(negedge CLK);
      if (sb.size() > 0) begin
        e = sb.pop_front();
        chk("PC_IF",    bus.PC_IF,          e.pc);
        chk("PC_IMEM",  bus.PC_IMEM,        e.imem);
        chk("pc_valid", 32'(bus.pc_valid),  32'(e.valid));
        chk("flushing", 32'(bus.flushing),  32'(e.flushing));
        chk("misalign", 32'(bus.misalign),  32'(e.mis));
        chk("epoch",    32'(bus.epoch),     32'(e.epoch));
      end else if (running && !stim_done) begin
        total++; bad++;
        $display("FAIL scoreboard: got empty queue want entry (t=%0t)", $time);
      end
    end
  end

  initial begin
    bus.EN = 1'b0; bus.PC_Sel = 2'b00; bus.PC_4 = '0; bus.PC_Branch = '0;
    bus.JR = '0; bus.PC_JAL = '0; bus.flush = 1'b0; bus.exc = 1'b0;
    m = reset_state();
    @(posedge CLK);
    #1;
    do_rst();
    repeat (5) drive(1'b1, 2'b00, '0, '0, '0, 1'b0, 1'b0);
    // Branch redirect, bubbles, then resume at target+4.
    drive(1'b1, 2'b01, 32'h40, '0, '0, 1'b1, 1'b0);
    repeat (5) drive(1'b1, 2'b00, '0, '0, '0, 1'b0, 1'b0);
    // flush and exc together, then a second flush inside the bubble window.
    drive(1'b1, 2'b11, '0, '0, 32'h100, 1'b1, 1'b1);
    drive(1'b1, 2'b00, '0, '0, '0, 1'b0, 1'b0);
    drive(1'b1, 2'b10, '0, 32'h200, '0, 1'b1, 1'b0);
    repeat (5) drive(1'b1, 2'b00, '0, '0, '0, 1'b0, 1'b0);
    // Stall with busy target inputs.
    repeat (4) drive(1'b0, 2'($urandom_range(0, 3)), $urandom, $urandom, $urandom, 1'b0, 1'b0);
    repeat (2) drive(1'b1, 2'b00, '0, '0, '0, 1'b0, 1'b0);
    // Misaligned JR redirect, then reset in the middle of the bubbles.
    drive(1'b1, 2'b10, '0, 32'h203, '0, 1'b1, 1'b0);
    drive(1'b1, 2'b00, '0, '0, '0, 1'b0, 1'b0);
    do_rst();
    repeat (3) drive(1'b1, 2'b00, '0, '0, '0, 1'b0, 1'b0);
    // Flush during BOOT.
    do_rst();
    drive(1'b1, 2'b01, 32'h77, '0, '0, 1'b1, 1'b0);
    repeat (4) drive(1'b1, 2'b00, '0, '0, '0, 1'b0, 1'b0);
    repeat (600) begin
      if ($urandom_range(0, 99) == 0)
        do_rst();
      else
        drive($urandom_range(0, 9) != 0, 2'($urandom_range(0, 3)), $urandom, $urandom,
              $urandom, $urandom_range(0, 9) == 0, $urandom_range(0, 19) == 0);
    end
    for (int i = 0; i < 20 && sb.size() > 0; i++) begin
      @(negedge CLK);
      #1;
    end
    stim_done = 1'b1;
    if (sb.size() > 0) begin
      total++; bad++;
      $display("FAIL drain: got %0d pending want 0", sb.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
